jtframe_joy_serial: RTL and testbench
=====================================

// Module: jtframe_joy_serial
// PURPOSE
// Parametrised reader for 74165-style joystick shift-register chains on the NeptUNO/MC2+ joy port.
// - Scans PLAYERS x BUTTONS serial bits per frame.
// - Filters each frame through a frame-compare debouncer.
// - Drives packed active-low joystick buses into the jtframe_mist joy*_bus inputs.
// - Adds multi-player support, configurable bit rate, debounce, scan enable and frame strobe.
// PARAMETERS
// PLAYERS   2  number of chained pads, 1..4
// BUTTONS   6  bits per pad, 4..12, serial order within pad: MSB first
// DIV       8  clk cycles per tick (half joy_clk_o period), >=2
// DEBOUNCE  2  identical consecutive frames needed to update joy_o, 1..15 (1 = no filter)
// PORTS
// clk        in   1                  system clock (clk_sys)
// rst_n      in   1                  asynchronous active-low reset
// en         in   1                  scan enable; sampled only in IDLE
// joy_data_i in   1                  serial data from chain (QH of last 74165)
// joy_clk_o  out  1                  shift clock to chain
// joy_load_o out  1                  parallel load, active low
// joy_o      out  PLAYERS*BUTTONS    debounced levels, active low (1=released), player p at [p*BUTTONS +: BUTTONS]
// raw_o      out  PLAYERS*BUTTONS    last complete unfiltered frame
// frame_o    out  1                  1-clk strobe when a frame completes (raw_o updated)
// BEHAVIOUR
// Reset state (async, rst_n low):
// - joy_o, raw_o all ones; joy_load_o=1; joy_clk_o=0; frame_o=0.
// - State IDLE; divider, bit counter and stable counter at 0; candidate all ones.
// Tick generation:
// - Free-running divider produces a 1-clk tick every DIV cycles.
// - All pin changes and data sampling occur only on ticks.
// State machine (N = PLAYERS*BUTTONS):
// - IDLE: on a tick with en=1 -> LOAD and drive joy_load_o=0. With en=0, stay in IDLE with pins idle.
// - LOAD: next tick -> joy_load_o=1, go to SAMPLE, bit counter = 0.
// - SAMPLE: on tick, shift joy_data_i into the shift register LSB (first bit ends up at bit N-1) and drive joy_clk_o=1 -> SHIFT.
// - SHIFT: on tick, drive joy_clk_o=0.
//   - If bit counter == N-1 -> DONE.
//   - Otherwise increment the counter -> SAMPLE.
// - DONE (one clk, no tick needed): raw_o <= shift register, frame_o=1, run debouncer -> IDLE.
// - Frame period = (2 + 2N) ticks, plus up to one tick of IDLE alignment.
//   - Example: DIV=8, N=12 gives 208..216 clk.
// Debouncer, run in DONE:
// - new frame == candidate: stable counter increments, saturating at DEBOUNCE.
// - new frame != candidate: candidate <= new frame and stable counter <= 1.
// - joy_o <= candidate whenever the updated counter == DEBOUNCE (same clk). With DEBOUNCE=1 this updates joy_o every frame.
// Boundary conditions:
// - en falling mid-frame: the current frame completes; the machine then waits in IDLE.
// - Reset mid-frame: the partial frame is discarded; pins return to idle levels immediately.
// - Bit counter width is $clog2(N). N=48 max.
// - Stable counter width is 4 bits.
// TESTING
// 1. Model: 2x 74165, 6 bits each, pad0=6'b111110, pad1=6'b011111, DEBOUNCE=1.
//    - First frame_o -> raw_o=joy_o=12'b111110_011111.
//    - Each frame shows exactly 12 joy_clk_o rising edges and exactly 1 joy_load_o low pulse of DIV clk.
// 2. DEBOUNCE=3, pattern switches from all-ones to 12'hFFE.
//    - joy_o stays 12'hFFF for 2 frames.
//    - On the 3rd matching frame's frame_o cycle, joy_o changes to 12'hFFE.
// 3. Glitch: a single frame of 12'h7FF between all-ones frames with DEBOUNCE=2.
//    - raw_o shows 12'h7FF for one frame; joy_o never leaves 12'hFFF.
// 4. Drop en at bit 5 of a frame.
//    - Frame completes with frame_o.
//    - No further joy_load_o pulse until en returns.
//    - The next load occurs within 1 tick of en=1.
// 5. Assert rst_n low mid-SHIFT.
//    - Outputs return to reset values asynchronously.
//    - After release, the first frame_o arrives after a full frame period with correct data.
// 6. PLAYERS=4, BUTTONS=12, DIV=2: frame period and bit packing are checked against the model for 100 random frames.

Source files
------------

// File: rtl/jtframe_joy_serial_if.sv
// jtframe_joy_serial_if
// ---------------------------------------------------------------------------
// Pin-level and output bus bundle of the 74165 joystick chain reader.
// The reader side uses the master modport. The consumer side (the core
// or a bench) uses the slave modport.
//
// Signals
//   en          consumer -> reader   scan enable, honoured only between frames
//   joy_data_i  chain    -> reader   serial data from QH of the last 74165
//   joy_clk_o   reader   -> chain    shift clock
//   joy_load_o  reader   -> chain    parallel load, active low
//   joy_o       reader   -> consumer debounced levels, active low (1=released),
//                                    player p at [p*BUTTONS +: BUTTONS]
//   raw_o       reader   -> consumer last complete unfiltered frame
//   frame_o     reader   -> consumer 1-clk strobe when raw_o is updated
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface jtframe_joy_serial_if #(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 6
);
    localparam int N = PLAYERS * BUTTONS;

    logic         en;
    logic         joy_data_i;
    logic         joy_clk_o;
    logic         joy_load_o;
    logic [N-1:0] joy_o;
    logic [N-1:0] raw_o;
    logic         frame_o;

    modport master (
        input  en,
        input  joy_data_i,
        output joy_clk_o,
        output joy_load_o,
        output joy_o,
        output raw_o,
        output frame_o
    );

    modport slave (
        output en,
        output joy_data_i,
        input  joy_clk_o,
        input  joy_load_o,
        input  joy_o,
        input  raw_o,
        input  frame_o
    );
endinterface

// File: rtl/jtframe_joy_serial.sv
// jtframe_joy_serial
// ---------------------------------------------------------------------------
// Reader for 74165-style joystick shift-register chains on the NeptUNO/MC2+
// joy port. Each frame loads the chain in parallel and then clocks out
// PLAYERS*BUTTONS bits. The first bit out ends up at bit N-1 of the frame.
// A frame-compare debouncer passes a frame to joy_o only after DEBOUNCE
// identical consecutive frames.
//
// Parameters
//   PLAYERS   number of chained pads, 1..4
//   BUTTONS   bits per pad, 4..12, MSB first within a pad
//   DIV       clk cycles per tick (half a joy_clk_o period), >= 2
//   DEBOUNCE  identical consecutive frames needed to update joy_o, 1..15
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    jtframe_joy_serial_if.master (chain pins, enable, outputs)
//
// Timing: each pin change and each data sample happens on a tick. A tick is
// one clk out of every DIV clks. With en held high, a frame takes exactly
// (2 + 2N) ticks, because the single-clk DONE state fits between two ticks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module jtframe_joy_serial #(
    parameter int PLAYERS  = 2,
    parameter int BUTTONS  = 6,
    parameter int DIV      = 8,
    parameter int DEBOUNCE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtframe_joy_serial_if.master  bus
);

    localparam int N  = PLAYERS * BUTTONS;
    localparam int CW = $clog2(N);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
    localparam logic [DW-1:0] DIV_TOP  = DW'(DIV - 1);
    localparam logic [3:0]    DEB_TOP  = 4'(DEBOUNCE);

    typedef enum logic [2:0] {
        ST_IDLE,    // pins idle, waiting for a tick with en=1
        ST_LOAD,    // joy_load_o low for one tick
        ST_SAMPLE,  // capture QH, then raise joy_clk_o
        ST_SHIFT,   // lower joy_clk_o, then next bit or finish
        ST_DONE     // one clk: publish frame and run the debouncer
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [CW-1:0]   r_bit;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    r_raw;
    logic [N-1:0]    r_cand;
    logic [N-1:0]    r_joy;
    logic [3:0]      r_stable;
    logic            r_clk;
    logic            r_load;
    logic            r_frame;

    logic            w_tick;
    logic            w_match;
    logic [3:0]      w_stable_next;

    // -----------------------------------------------------------------------
    // Tick divider: free running. It is never restarted by the FSM, so an
    // enable arriving in IDLE waits at most one tick.
    // -----------------------------------------------------------------------
    assign w_tick = (r_div == DIV_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            // NOTE: state is always updated with <= so every flop samples pre-edge values.
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Debouncer next-count. A differing frame becomes the new candidate with
    // a count of 1. A matching frame counts up and saturates at DEBOUNCE.
    // -----------------------------------------------------------------------
    assign w_match = (r_shift == r_cand);

    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        w_stable_next = 4'd1;
        if (w_match) begin
            w_stable_next = (r_stable >= DEB_TOP) ? DEB_TOP : (r_stable + 4'd1);
        end
    end

    // -----------------------------------------------------------------------
    // Frame sequencer with registered pin and strobe outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register has a defined reset value here. There is no memory array, so nothing is left unreset.
            r_state  <= ST_IDLE;
            r_bit    <= '0;
            r_shift  <= '1;
            r_raw    <= '1;
            r_cand   <= '1;
            r_joy    <= '1;
            r_stable <= 4'd0;
            r_clk    <= 1'b0;
            r_load   <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_tick && bus.en) begin
                        r_load  <= 1'b0;
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (w_tick) begin
                        r_load  <= 1'b1;
                        r_bit   <= '0;
                        r_state <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    // QH already shows the current bit. The rising joy_clk_o
                    // moves the chain to the next bit.
                    if (w_tick) begin
                        r_shift <= {r_shift[N-2:0], bus.joy_data_i};
                        r_clk   <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (w_tick) begin
                        r_clk <= 1'b0;
                        if (r_bit == LAST_BIT) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_bit   <= r_bit + CW'(1);
                            r_state <= ST_SAMPLE;
                        end
                    end
                end

                ST_DONE: begin
                    r_raw    <= r_shift;
                    r_frame  <= 1'b1;
                    // After this update the candidate always equals the new
                    // frame, so joy_o takes r_shift directly.
                    r_cand   <= r_shift;
                    r_stable <= w_stable_next;
                    if (w_stable_next == DEB_TOP) begin
                        r_joy <= r_shift;
                    end
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.joy_clk_o  = r_clk;
    assign bus.joy_load_o = r_load;
    assign bus.joy_o      = r_joy;
    assign bus.raw_o      = r_raw;
    assign bus.frame_o    = r_frame;

endmodule

// File: tb/tb_jtframe_joy_serial.sv
// tb_jtframe_joy_serial
// ---------------------------------------------------------------------------
// Bench for jtframe_joy_serial.
// - Group: three 2x6 readers with DIV=8 share a clock, reset and enable.
//   They use DEBOUNCE = 1, 3 and 2. Each reader has its own 74165 chain model.
// - Instance D: a 4x12 reader with DIV=2 and DEBOUNCE=2, driven with random
//   frames. A reference debouncer based on run length checks its outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_jtframe_joy_serial;

    localparam logic [11:0] PAT_A  = 12'b111110_011111;
    localparam int          DIV_G  = 8;
    localparam int          N_G    = 12;
    localparam int          N_D    = 48;
    localparam int          DIV_D  = 2;
    localparam int          DEB_D  = 2;
    localparam int          PER_G  = (2 + 2 * N_G) * DIV_G;   // 208
    localparam int          PER_D  = (2 + 2 * N_D) * DIV_D;   // 196

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_g;
    logic rst_n_d;
    logic en_g;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // -----------------------------------------------------------------------
    // Group of three 12-bit readers
    // -----------------------------------------------------------------------
    logic [11:0]       g_pat [3];
    logic [2:0][11:0]  g_joy;
    logic [2:0][11:0]  g_raw;
    logic [2:0]        g_clk;
    logic [2:0]        g_load;
    logic [2:0]        g_frame;

    for (genvar g = 0; g < 3; g++) begin : gen_grp
        localparam int DEB = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        logic [11:0] sr;
        logic        clk_q;

        jtframe_joy_serial_if #(.PLAYERS(2), .BUTTONS(6)) bus ();

        assign bus.en         = en_g;
        assign bus.joy_data_i = sr[11];
        assign g_joy[g]       = bus.joy_o;
        assign g_raw[g]       = bus.raw_o;
        assign g_clk[g]       = bus.joy_clk_o;
        assign g_load[g]      = bus.joy_load_o;
        assign g_frame[g]     = bus.frame_o;

        jtframe_joy_serial #(.PLAYERS(2), .BUTTONS(6), .DIV(DIV_G), .DEBOUNCE(DEB)) dut (
            .clk   (clk),
            .rst_n (rst_n_g),
            .bus   (bus.master)
        );

        // 74165 chain. Load low copies the pattern in. Each rising shift
        // clock moves the next bit to QH. Ones fill in from the serial input.
        always @(posedge clk) begin
            clk_q <= bus.joy_clk_o;
            if (!bus.joy_load_o) sr <= g_pat[g];
            else if (bus.joy_clk_o && !clk_q) sr <= {sr[10:0], 1'b1};
        end
    end

    // Pin activity monitor for reader A, sampled on the falling edge
    int   a_rises, a_frame_rises, a_loads, a_frame_loads, a_low, a_last_w, a_load_total;
    logic a_clk_q, a_load_q;
    logic c_glitch;

    always @(negedge clk) begin
        if (!rst_n_g) begin
            a_rises  <= 0;
            a_loads  <= 0;
            a_low    <= 0;
            a_clk_q  <= 1'b0;
            a_load_q <= 1'b1;
        end else begin
            a_clk_q  <= g_clk[0];
            a_load_q <= g_load[0];
            if (g_frame[0]) begin
                a_frame_rises <= a_rises;
                a_frame_loads <= a_loads;
                a_rises       <= 0;
                a_loads       <= 0;
            end else begin
                if (g_clk[0] && !a_clk_q) a_rises <= a_rises + 1;
                if (!g_load[0] && a_load_q) begin
                    a_loads      <= a_loads + 1;
                    a_load_total <= a_load_total + 1;
                end
            end
            if (!g_load[0]) a_low <= a_low + 1;
            else if (!a_load_q) begin
                a_last_w <= a_low;
                a_low    <= 0;
            end
            if (g_joy[2] != 12'hFFF) c_glitch <= 1'b1;
        end
    end

    task automatic wait_frame_g(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!g_frame[0] && cycles < 1000);
        if (!g_frame[0]) begin
            n_chk++;
            $display("FAIL frame_g timeout: got no frame_o expected one within 1000 clk");
        end
    endtask

    task automatic wait_rises(input int n);
        int t;
        t = 0;
        while (a_rises != n && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (a_rises != n) begin
            n_chk++;
            $display("FAIL rises timeout: got %0d expected %0d", a_rises, n);
        end
    endtask

    // -----------------------------------------------------------------------
    // Instance D: 4 players x 12 buttons, DIV=2
    // -----------------------------------------------------------------------
    logic [47:0] d_pat;
    logic [47:0] d_sr;
    logic        d_clk_q;

    jtframe_joy_serial_if #(.PLAYERS(4), .BUTTONS(12)) bus_d ();

    assign bus_d.en         = 1'b1;
    assign bus_d.joy_data_i = d_sr[47];

    jtframe_joy_serial #(.PLAYERS(4), .BUTTONS(12), .DIV(DIV_D), .DEBOUNCE(DEB_D)) dut_d (
        .clk   (clk),
        .rst_n (rst_n_d),
        .bus   (bus_d.master)
    );

    always @(posedge clk) begin
        d_clk_q <= bus_d.joy_clk_o;
        if (!bus_d.joy_load_o) d_sr <= d_pat;
        else if (bus_d.joy_clk_o && !d_clk_q) d_sr <= {d_sr[46:0], 1'b1};
    end

    task automatic wait_frame_d(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus_d.frame_o && cycles < 1000);
        if (!bus_d.frame_o) begin
            n_chk++;
            $display("FAIL frame_d timeout: got no frame_o expected one within 1000 clk");
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus table for readers B (DEBOUNCE=3) and C (DEBOUNCE=2)
    // -----------------------------------------------------------------------
    typedef struct {
        logic [11:0] pat_b;
        logic [11:0] pat_c;
        logic [11:0] raw_b;
        logic [11:0] joy_b;
        logic [11:0] raw_c;
        logic [11:0] joy_c;
    } vec_t;

    vec_t vec [5];

    initial begin
        int cyc;
        int t;
        int lt;
        int run;
        int reps;
        logic [47:0] cur;
        logic [47:0] prev;
        logic [47:0] exp_joy;

        // Frame-by-frame expectations
        vec[0] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        vec[1] = '{12'hFFE, 12'hFFF, 12'hFFE, 12'hFFF, 12'hFFF, 12'hFFF};
        vec[2] = '{12'hFFE, 12'h7FF, 12'hFFE, 12'hFFF, 12'h7FF, 12'hFFF};
        vec[3] = '{12'hFFE, 12'hFFF, 12'hFFE, 12'hFFE, 12'hFFF, 12'hFFF};
        vec[4] = '{12'hFFE, 12'hFFF, 12'hFFE, 12'hFFE, 12'hFFF, 12'hFFF};

        en_g         = 1'b1;
        rst_n_g      = 1'b0;
        rst_n_d      = 1'b0;
        g_pat[0]     = PAT_A;
        g_pat[1]     = vec[0].pat_b;
        g_pat[2]     = vec[0].pat_c;
        d_pat        = '1;
        a_load_total = 0;
        c_glitch     = 1'b0;

        repeat (4) @(negedge clk);
        check("rst joy_a",   g_joy[0],   12'hFFF);
        check("rst raw_a",   g_raw[0],   12'hFFF);
        check("rst clk_a",   g_clk[0],   1'b0);
        check("rst load_a",  g_load[0],  1'b1);
        check("rst frame_a", g_frame[0], 1'b0);
        check("rst joy_d",   bus_d.joy_o, 48'hFFFF_FFFF_FFFF);
        check("rst raw_d",   bus_d.raw_o, 48'hFFFF_FFFF_FFFF);

        // Basic read, DEBOUNCE 3 step and DEBOUNCE 2 glitch rejection
        rst_n_g = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g_pat[1] = vec[k].pat_b;
            g_pat[2] = vec[k].pat_c;
            wait_frame_g(cyc);
            if (k == 0) check_range("first frame latency", cyc, PER_G, PER_G + DIV_G + 1);
            else        check_range("frame period g", cyc, PER_G, PER_G + DIV_G);
            check("raw_a", g_raw[0], PAT_A);
            check("joy_a", g_joy[0], PAT_A);
            check("raw_b", g_raw[1], vec[k].raw_b);
            check("joy_b", g_joy[1], vec[k].joy_b);
            check("raw_c", g_raw[2], vec[k].raw_c);
            check("joy_c", g_joy[2], vec[k].joy_c);
            #1;
            check("clk rises per frame", a_frame_rises, N_G);
            check("loads per frame",     a_frame_loads, 1);
            check("load pulse width",    a_last_w,      DIV_G);
        end
        check("joy_c never left FFF", c_glitch, 1'b0);

        // Drop en at bit 5: the frame completes, then the reader stays idle
        wait_rises(5);
        en_g = 1'b0;
        wait_frame_g(cyc);
        check("en drop raw_a", g_raw[0], PAT_A);
        #1;
        check("en drop rises", a_frame_rises, N_G);
        lt = a_load_total;
        repeat (3 * PER_G) @(negedge clk);
        check("no load while en=0", a_load_total, lt);
        check("idle load pin",      g_load[0], 1'b1);
        check("idle clk pin",       g_clk[0],  1'b0);
        en_g = 1'b1;
        t = 0;
        while (g_load[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_range("load after en", t, 1, DIV_G);
        wait_frame_g(cyc);
        check("after en raw_a", g_raw[0], PAT_A);

        // Reset while SHIFT is active
        wait_rises(3);
        t = 0;
        while (!g_clk[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached shift", g_clk[0], 1'b1);
        #2 rst_n_g = 1'b0;
        #1;
        check("async rst joy_a",   g_joy[0],   12'hFFF);
        check("async rst raw_a",   g_raw[0],   12'hFFF);
        check("async rst clk_a",   g_clk[0],   1'b0);
        check("async rst load_a",  g_load[0],  1'b1);
        check("async rst frame_a", g_frame[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n_g = 1'b1;
        wait_frame_g(cyc);
        check_range("post-reset latency", cyc, PER_G, PER_G + DIV_G + 1);
        check("post-reset raw_a", g_raw[0], PAT_A);
        check("post-reset joy_a", g_joy[0], PAT_A);

        // Random frames on the 4x12 reader against the run-length reference
        cur     = 48'({$urandom(), $urandom()});
        reps    = $urandom_range(1, 3);
        d_pat   = cur;
        prev    = '1;
        run     = 0;
        exp_joy = '1;
        @(negedge clk);
        rst_n_d = 1'b1;
        for (int f = 0; f < 100; f++) begin
            wait_frame_d(cyc);
            if (f > 0) check_range("frame period d", cyc, PER_D, PER_D + DIV_D);
            if (f > 0 && cur == prev) run++;
            else run = 1;
            if (run >= DEB_D) exp_joy = cur;
            check("raw_d", bus_d.raw_o, cur);
            check("joy_d", bus_d.joy_o, exp_joy);
            prev = cur;
            reps--;
            if (reps == 0) begin
                cur  = ($urandom_range(0, 4) == 0) ? '1 : 48'({$urandom(), $urandom()});
                reps = $urandom_range(1, 3);
            end
            d_pat = cur;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
